branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Back end of the branch prediction loop. It takes resolved branch outcomes from the branch-confirming stage and compares each one against the prediction the fetch stage attached to that instruction. On a misprediction it issues a one-cycle redirect (irregPc plus flush request). It owns and trains the direction predictor (PHT) and the BTB, and serves the fetch stage's synchronous lookups from both.

## Interface
Parameters:
- ADDR_WIDTH, 32, PC width
- PHT_ENTRIES, 64, 2-bit counters, power of two
- BTB_ENTRIES, 32, direct-mapped entries, power of two

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- stall  in  1  fetch stall; holds lookup outputs
- lookupPc  in  ADDR_WIDTH  next-PC from fetch (same address fed to IMem)
- isBranchTakenPredicted  out  1  PHT prediction for lookupPc, registered
- btbHit  out  1  BTB valid and tag match for lookupPc, registered
- btbPredictedPc  out  ADDR_WIDTH  BTB target, registered
- resolveValid  in  1  a branch resolves this cycle
- resolveKill  in  1  squash resolve (older flush); overrides resolveValid
- resolvePc  in  ADDR_WIDTH  branch PC
- resolveTaken  in  1  actual direction
- resolveTarget  in  ADDR_WIDTH  actual taken target
- predIsNextPcPredicted, predTaken  in  1 each  branchPredict fields carried down the pipe
- predNextPc  in  ADDR_WIDTH  predictedNextPC carried down the pipe
- irregPc  out  ADDR_WIDTH  redirect PC; 0 = no redirect
- flushReq  out  1  flush younger stages
- mispredictCount, branchCount  out  32 each  performance counters

## Operation
- Accepted resolve: resolveValid && !resolveKill.
- Misprediction rules for an accepted resolve:
  - predIsNextPcPredicted && predTaken: mispredict if !resolveTaken, or if resolveTarget != predNextPc.
  - predIsNextPcPredicted && !predTaken: mispredict if resolveTaken.
  - !predIsNextPcPredicted: mispredict if resolveTaken.
- Redirect value: resolveTaken ? resolveTarget : resolvePc + 4. Address arithmetic is modulo 2^ADDR_WIDTH.
- A redirect to address 0 cannot be encoded, because 0 means no redirect. It is unsupported.
- PHT:
  - Index is resolvePc[log2(PHT_ENTRIES)+1:2].
  - 2-bit saturating counter: taken increments, saturating at 3; not-taken decrements, saturating at 0.
  - Prediction is counter[1].
- BTB:
  - Index is pc[log2(BTB_ENTRIES)+1:2]; tag is the remaining upper PC bits.
  - Written {valid, tag, resolveTarget} on every accepted taken resolve.
  - Entries are never invalidated except by reset.
- Both tables update on the clock edge after the accepted resolve.
- Lookup and update of the same index in the same cycle returns the old value (read-first).

## Timing
- Reset values:
  - All PHT counters = 2'b01 (weakly not-taken); all BTB valid = 0.
  - isBranchTakenPredicted = 0, btbHit = 0, btbPredictedPc = 0.
  - irregPc = 0, flushReq = 0, both counters = 0.
- Lookup latency: 1 cycle. Outputs reflect the lookupPc sampled at the previous edge, aligned with the IMem read.
- While stall = 1, lookup output registers hold.
- Redirect latency: irregPc/flushReq are registered and asserted exactly one cycle after an accepted mispredicting resolve, for one cycle only. Otherwise 0.
- Back-to-back resolves on consecutive cycles each produce their own redirect pulse; no merging.
- resolveKill in the same cycle as resolveValid: no redirect, no table update, no count.
- Reset asserted mid-operation: all state clears immediately; any pending redirect pulse is dropped.

## Configuration
- PERF_COUNTER_EN defined:
  - branchCount increments on every accepted resolve.
  - mispredictCount increments on every accepted misprediction.
  - Both saturate at 2^32-1.
- PERF_COUNTER_EN undefined: both counters are not built, and the ports are driven constant 0.

## Structure
- The shared package (BasicTypes) holds:
  - BranchResolveInfo struct: pc, taken, target.
  - PhtCounter typedef (logic [1:0]) and the PHT_INIT = 2'b01 constant.
  - BtbEntry struct: valid, tag, target.
- One sub-module, BranchTargetBuffer, contains the BTB storage, the lookup register and read-first write. PHT and mispredict logic stay in the top module.

## Test plan
- After reset, lookupPc=0x100 → next cycle isBranchTakenPredicted=0, btbHit=0.
- Resolve pc=0x100, taken, target=0x200, pred fields all 0 → next cycle irregPc=0x200, flushReq=1; one cycle later both are 0. Then lookupPc=0x100 → btbHit=1, btbPredictedPc=0x200, isBranchTakenPredicted=1 (counter is now 2).
- Resolve pc=0x100 not-taken with predTaken=1, predIsNextPcPredicted=1, predNextPc=0x200 → irregPc=0x104. Counter steps 2→1, so the next lookup predicts not-taken.
- Predicted target 0x200, actual target 0x300, taken → irregPc=0x300, and the BTB entry is overwritten to 0x300.
- resolveValid=1 with resolveKill=1 on a mispredicting branch → irregPc stays 0, the PHT is unchanged, and branchCount is unchanged.
- With PERF_COUNTER_EN: 3 resolves, 2 of them mispredicted → branchCount=3, mispredictCount=2. With the macro off, both read 0.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_resolve_unit_pkg: shared predictor types and the 2-bit counter update rule.
package branch_resolve_unit_pkg;
  typedef logic [1:0] pht_counter_t;
  localparam pht_counter_t PHT_INIT = 2'b01;
  function automatic pht_counter_t pht_update(input pht_counter_t c, input logic taken);
    return taken ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/branch_resolve_unit_btb.sv
// branch_resolve_unit_btb: direct-mapped BTB with registered, stallable, read-first lookup.
module branch_resolve_unit_btb
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_pc,
  input  logic [ADDR_WIDTH-1:0] wr_target,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] target
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = ADDR_WIDTH - IW - 2;
  typedef struct packed {
    logic                  valid;
    logic [TW-1:0]         tag;
    logic [ADDR_WIDTH-1:0] target;
  } btb_entry_t;
  btb_entry_t mem [ENTRIES];
  btb_entry_t rd;
  logic [IW-1:0] rd_idx, wr_idx;
  logic rd_hit;
  logic unused_pc_bits;
  assign rd_idx = lookup_pc[IW+1:2];
  assign wr_idx = wr_pc[IW+1:2];
  assign rd = mem[rd_idx];
  assign rd_hit = rd.valid && rd.tag == lookup_pc[ADDR_WIDTH-1:IW+2];
  assign unused_pc_bits = ^{lookup_pc[1:0], wr_pc[1:0]};
  // Nonblocking write with a same-edge read gives read-first behaviour.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
      hit <= 1'b0;
      target <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= '{1'b1, wr_pc[ADDR_WIDTH-1:IW+2], wr_target};
      if (!stall) begin
        hit <= rd_hit;
        target <= rd_hit ? rd.target : '0;
      end
    end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: mispredict detection/redirect, PHT and BTB training and lookup.
// Optional performance counters are built when PERF_COUNTER_EN is defined.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int PHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] lookupPc,
  output logic                  isBranchTakenPredicted,
  output logic                  btbHit,
  output logic [ADDR_WIDTH-1:0] btbPredictedPc,
  input  logic                  resolveValid,
  input  logic                  resolveKill,
  input  logic [ADDR_WIDTH-1:0] resolvePc,
  input  logic                  resolveTaken,
  input  logic [ADDR_WIDTH-1:0] resolveTarget,
  input  logic                  predIsNextPcPredicted,
  input  logic                  predTaken,
  input  logic [ADDR_WIDTH-1:0] predNextPc,
  output logic [ADDR_WIDTH-1:0] irregPc,
  output logic                  flushReq,
  output logic [31:0]           mispredictCount,
  output logic [31:0]           branchCount
);
  localparam int PW = $clog2(PHT_ENTRIES);
  pht_counter_t pht [PHT_ENTRIES];
  logic [PW-1:0] res_idx, look_idx;
  logic accepted, mispredict;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  assign res_idx = resolvePc[PW+1:2];
  assign look_idx = lookupPc[PW+1:2];
  assign accepted = resolveValid && !resolveKill;
  assign mispredict = predIsNextPcPredicted && predTaken
                    ? (!resolveTaken || resolveTarget != predNextPc)
                    : resolveTaken;
  assign redirect_pc = resolveTaken ? resolveTarget : resolvePc + ADDR_WIDTH'(4);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= PHT_INIT;
      isBranchTakenPredicted <= 1'b0;
      irregPc <= '0;
      flushReq <= 1'b0;
    end else begin
      if (accepted) pht[res_idx] <= pht_update(pht[res_idx], resolveTaken);
      if (!stall) isBranchTakenPredicted <= pht[look_idx][1];
      irregPc <= accepted && mispredict ? redirect_pc : '0;
      flushReq <= accepted && mispredict;
    end
  branch_resolve_unit_btb #(.ADDR_WIDTH(ADDR_WIDTH), .ENTRIES(BTB_ENTRIES)) u_btb (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .lookup_pc(lookupPc),
    .wr_en(accepted && resolveTaken),
    .wr_pc(resolvePc),
    .wr_target(resolveTarget),
    .hit(btbHit),
    .target(btbPredictedPc)
  );
`ifdef PERF_COUNTER_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      branchCount <= '0;
      mispredictCount <= '0;
    end else begin
      if (accepted && branchCount != '1) branchCount <= branchCount + 32'd1;
      if (accepted && mispredict && mispredictCount != '1) mispredictCount <= mispredictCount + 32'd1;
    end
`else
  assign branchCount = '0;
  assign mispredictCount = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench for branch_resolve_unit with a reference predictor model.
module tb_branch_resolve_unit;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0;
  logic [31:0] lookupPc = '0, resolvePc = '0, resolveTarget = '0, predNextPc = '0;
  logic resolveValid = 1'b0, resolveKill = 1'b0, resolveTaken = 1'b0;
  logic predIsNextPcPredicted = 1'b0, predTaken = 1'b0;
  logic isBranchTakenPredicted, btbHit, flushReq;
  logic [31:0] btbPredictedPc, irregPc, mispredictCount, branchCount;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .lookupPc(lookupPc),
    .isBranchTakenPredicted(isBranchTakenPredicted), .btbHit(btbHit), .btbPredictedPc(btbPredictedPc),
    .resolveValid(resolveValid), .resolveKill(resolveKill), .resolvePc(resolvePc),
    .resolveTaken(resolveTaken), .resolveTarget(resolveTarget),
    .predIsNextPcPredicted(predIsNextPcPredicted), .predTaken(predTaken), .predNextPc(predNextPc),
    .irregPc(irregPc), .flushReq(flushReq), .mispredictCount(mispredictCount), .branchCount(branchCount)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] irreg; logic flush; } redir_t;
  typedef struct { logic pred; logic hit; logic [31:0] tgt; } look_t;
  redir_t rq[$];
  look_t lq[$];
  look_t last_look;
  int n_checks = 0, n_fail = 0;
  logic [1:0] m_pht [64];
  logic m_v [32];
  logic [24:0] m_tag [32];
  logic [31:0] m_tgt [32];
  int unsigned m_br, m_mis;
  logic [31:0] pcs [5] = '{32'h100, 32'h104, 32'h180, 32'h1100, 32'h2040};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_pht[i] = 2'b01;
    for (int i = 0; i < 32; i++) begin m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; end
    m_br = 0;
    m_mis = 0;
    last_look = '{1'b0, 1'b0, 32'h0};
  endtask

  task automatic look(input logic [31:0] pc, input logic stl);
    look_t e;
    int bi;
    lookupPc = pc;
    stall = stl;
    bi = int'(pc[6:2]);
    if (stl) e = last_look;
    else begin
      e.pred = m_pht[pc[7:2]][1];
      e.hit = m_v[bi] && m_tag[bi] == pc[31:7];
      e.tgt = e.hit ? m_tgt[bi] : 32'h0;
    end
    last_look = e;
    lq.push_back(e);
  endtask

  task automatic res(input logic [31:0] pc, input logic taken, input logic [31:0] target,
                     input logic pit, input logic pt, input logic [31:0] pnp, input logic kill);
    redir_t r;
    logic mis;
    resolveValid = 1'b1; resolveKill = kill; resolvePc = pc; resolveTaken = taken;
    resolveTarget = target; predIsNextPcPredicted = pit; predTaken = pt; predNextPc = pnp;
    mis = (pit && pt) ? (!taken || target != pnp) : taken;
    r.flush = !kill && mis;
    r.irreg = r.flush ? (taken ? target : pc + 32'd4) : 32'h0;
    rq.push_back(r);
    if (!kill) begin
      m_pht[pc[7:2]] = taken ? (m_pht[pc[7:2]] == 2'b11 ? 2'b11 : m_pht[pc[7:2]] + 2'b01)
                             : (m_pht[pc[7:2]] == 2'b00 ? 2'b00 : m_pht[pc[7:2]] - 2'b01);
      if (taken) begin m_v[pc[6:2]] = 1'b1; m_tag[pc[6:2]] = pc[31:7]; m_tgt[pc[6:2]] = target; end
      m_br++;
      if (mis) m_mis++;
    end
  endtask

  task automatic tick();
    redir_t r;
    look_t l;
    @(posedge clk);
    #1;
    resolveValid = 1'b0;
    resolveKill = 1'b0;
    stall = 1'b0;
    r = rq.size() > 0 ? rq.pop_front() : '{32'h0, 1'b0};
    check("irregPc", irregPc, r.irreg);
    check("flushReq", flushReq, r.flush);
    if (lq.size() > 0) begin
      l = lq.pop_front();
      check("pred", isBranchTakenPredicted, l.pred);
      check("btbHit", btbHit, l.hit);
      check("btbPredictedPc", btbPredictedPc, l.tgt);
    end
  endtask

  task automatic check_counts();
`ifdef PERF_COUNTER_EN
    check("branchCount", branchCount, m_br);
    check("mispredictCount", mispredictCount, m_mis);
`else
    check("branchCount", branchCount, 0);
    check("mispredictCount", mispredictCount, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_irregPc", irregPc, 0);
    check("rst_flushReq", flushReq, 0);
    check("rst_pred", isBranchTakenPredicted, 0);
    check("rst_btbHit", btbHit, 0);
    check("rst_btbPredictedPc", btbPredictedPc, 0);
    check_counts();
    @(negedge clk) rst = 1'b1;
    look(32'h100, 0); tick();
    res(32'h100, 1, 32'h200, 0, 0, 0, 0); tick(); tick();
    look(32'h100, 0); tick();
    res(32'h100, 1, 32'h200, 1, 1, 32'h200, 0); tick();
    res(32'h100, 0, 32'h0, 1, 1, 32'h200, 0); tick();
    check_counts();
    res(32'h100, 0, 32'h0, 1, 1, 32'h200, 0); tick();
    look(32'h100, 0); tick();
    res(32'h100, 1, 32'h300, 1, 1, 32'h200, 0); tick();
    look(32'h100, 0); tick();
    res(32'h180, 1, 32'h400, 0, 0, 0, 1); tick();
    look(32'h180, 0); tick();
    check_counts();
    look(32'h100, 0); res(32'h100, 1, 32'h500, 0, 0, 0, 0); tick();
    look(32'h100, 0); tick();
    look(32'h2040, 0); tick();
    look(32'h100, 1); tick();
    look(32'h100, 0); tick();
    res(32'h40, 1, 32'h80, 0, 0, 0, 0); tick();
    res(32'h44, 0, 32'h0, 1, 0, 0, 0); tick();
    res(32'h48, 0, 32'h0, 1, 1, 32'h60, 0); tick(); tick();
    res(32'hFFFF_FFF8, 0, 32'h0, 1, 1, 32'h10, 0); tick();
    repeat (4) begin res(32'h2040, 1, 32'h3000, 1, 1, 32'h3000, 0); tick(); end
    look(32'h2040, 0); tick();
    repeat (5) begin res(32'h2040, 0, 32'h0, 0, 0, 0, 0); tick(); end
    look(32'h2040, 0); tick();
    for (int i = 0; i < 80; i++) begin
      look(pcs[$urandom_range(0, 4)], i > 0 && $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) != 0)
        res(pcs[$urandom_range(0, 4)], 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 3)) * 4,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h1000 + 32'($urandom_range(0, 3)) * 4,
            $urandom_range(0, 7) == 0);
      tick();
    end
    tick();
    check_counts();
    resolveValid = 1'b1; resolveKill = 1'b0; resolvePc = 32'h100; resolveTaken = 1'b1;
    resolveTarget = 32'h900; predIsNextPcPredicted = 1'b0; predTaken = 1'b0;
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    resolveValid = 1'b0;
    check("rstmid_irregPc", irregPc, 0);
    check("rstmid_flushReq", flushReq, 0);
    check_counts();
    @(negedge clk) rst = 1'b1;
    look(32'h100, 0); tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
